// File: rtl/sprite_blitter.sv
// Copies a 16x16 sprite from ROM into the frame RAM once vblank opens, clipping at the frame edges.
// Write pipeline is 2 cycles deep (ROM read, then register). Optional macro BLIT_TRANSPARENT_EN skips color index 0.
module sprite_blitter #(
   parameter int FB_WIDTH  = 640,
   parameter int FB_HEIGHT = 480
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        start,
   input  logic [9:0]  sprite_x,
   input  logic [9:0]  sprite_y,
   input  logic [2:0]  sprite_id,
   input  logic        vblank,
   output logic [10:0] rom_addr,
   input  logic [3:0]  rom_data,
   output logic        fb_we,
   output logic [19:0] fb_addr,
   output logic [3:0]  fb_data,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_VB,
      S_RUN,
      S_FLUSH,
      S_DONE
   } state_t;

   localparam logic [19:0] FB_W20 = 20'(FB_WIDTH);
   localparam logic [19:0] FB_H20 = 20'(FB_HEIGHT);

   state_t      state_q, state_d;
   logic [9:0]  x_q, x_d;
   logic [9:0]  y_q, y_d;
   logic [2:0]  id_q, id_d;
   logic [3:0]  row_q, row_d;
   logic [3:0]  col_q, col_d;
   logic        flush_q, flush_d;
   logic        p1_vld_q, p1_vld_d;
   logic        p1_clip_q, p1_clip_d;
   logic [19:0] p1_addr_q, p1_addr_d;
   logic        fb_we_q, fb_we_d;
   logic [19:0] fb_addr_q, fb_addr_d;
   logic [3:0]  fb_data_q, fb_data_d;
   logic [19:0] col_abs, row_abs;

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      id_d    = id_q;
      row_d   = row_q;
      col_d   = col_q;
      flush_d = flush_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               x_d     = sprite_x;
               y_d     = sprite_y;
               id_d    = sprite_id;
               row_d   = 4'd0;
               col_d   = 4'd0;
               state_d = S_WAIT_VB;
            end
         end
         S_WAIT_VB: begin
            if (vblank) state_d = S_RUN;
         end
         S_RUN: begin
            // vblank is no longer consulted: a started blit always finishes.
            col_d = col_q + 4'd1;
            if (col_q == 4'd15) row_d = row_q + 4'd1;
            if (row_q == 4'd15 && col_q == 4'd15) begin
               state_d = S_FLUSH;
               flush_d = 1'b0;
            end
         end
         S_FLUSH: begin
            flush_d = 1'b1;
            if (flush_q) state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Stage 1 runs alongside the ROM read; sums are 20 bits so clipping sees the true position.
   always_comb begin
      col_abs   = {10'd0, x_q} + {16'd0, col_q};
      row_abs   = {10'd0, y_q} + {16'd0, row_q};
      p1_vld_d  = (state_q == S_RUN);
      p1_clip_d = (col_abs >= FB_W20) || (row_abs >= FB_H20);
      p1_addr_d = row_abs * FB_W20 + col_abs;
   end

   always_comb begin
`ifdef BLIT_TRANSPARENT_EN
      fb_we_d = p1_vld_q && !p1_clip_q && (rom_data != 4'h0);
`else
      fb_we_d = p1_vld_q && !p1_clip_q;
`endif
      fb_addr_d = p1_vld_q ? p1_addr_q : fb_addr_q;
      fb_data_d = p1_vld_q ? rom_data : fb_data_q;
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state_q   <= S_IDLE;
         x_q       <= 10'd0;
         y_q       <= 10'd0;
         id_q      <= 3'd0;
         row_q     <= 4'd0;
         col_q     <= 4'd0;
         flush_q   <= 1'b0;
         p1_vld_q  <= 1'b0;
         p1_clip_q <= 1'b0;
         p1_addr_q <= 20'd0;
         fb_we_q   <= 1'b0;
         fb_addr_q <= 20'd0;
         fb_data_q <= 4'd0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         id_q      <= id_d;
         row_q     <= row_d;
         col_q     <= col_d;
         flush_q   <= flush_d;
         p1_vld_q  <= p1_vld_d;
         p1_clip_q <= p1_clip_d;
         p1_addr_q <= p1_addr_d;
         fb_we_q   <= fb_we_d;
         fb_addr_q <= fb_addr_d;
         fb_data_q <= fb_data_d;
      end
   end

   assign rom_addr = {id_q, row_q, col_q};
   assign fb_we    = fb_we_q;
   assign fb_addr  = fb_addr_q;
   assign fb_data  = fb_data_q;
   assign busy     = (state_q == S_WAIT_VB) || (state_q == S_RUN) || (state_q == S_FLUSH);
   assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: ROM model, write logger and per-scenario checks.
module tb_sprite_blitter;

   logic        CLK = 1'b0;
   logic        RESET_N, start, vblank;
   logic [9:0]  sprite_x, sprite_y;
   logic [2:0]  sprite_id;
   logic [10:0] rom_addr;
   logic [3:0]  rom_data;
   logic        fb_we;
   logic [19:0] fb_addr;
   logic [3:0]  fb_data;
   logic        busy, done;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int rom_mode = 0;
   int st_cyc;
   int wr_addr[$];
   int wr_data[$];
   int wr_cyc[$];
   int exp_addr[$];
   int exp_data[$];
   int done_cnt = 0;
   int done_cyc = -1;

   sprite_blitter #(.FB_WIDTH(640), .FB_HEIGHT(480)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .start(start),
      .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_id(sprite_id),
      .vblank(vblank), .rom_addr(rom_addr), .rom_data(rom_data),
      .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
      .busy(busy), .done(done)
   );

   always #5 CLK = ~CLK;

   function automatic logic [3:0] rom_fn(input logic [10:0] a);
      if (rom_mode == 1) return (a[3:0] == 4'd0) ? 4'h5 : 4'h0;
      return 4'(int'(a[10:8]) * 3 + int'(a[7:4]) + int'(a[3:0]) * 5);
   endfunction

   always @(posedge CLK) begin
      cyc      <= cyc + 1;
      rom_data <= rom_fn(rom_addr);
   end

   always @(negedge CLK) begin
      if (fb_we === 1'b1) begin
         wr_addr.push_back(int'(fb_addr));
         wr_data.push_back(int'(fb_data));
         wr_cyc.push_back(cyc);
      end
      if (done === 1'b1) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
   end

   task automatic clear_log();
      wr_addr.delete();
      wr_data.delete();
      wr_cyc.delete();
      done_cnt = 0;
      done_cyc = -1;
   endtask

   // Reference write list straight from the address/clip rules.
   task automatic build_exp(input int x, input int y, input int id);
      logic [3:0] d;
      exp_addr.delete();
      exp_data.delete();
      for (int r = 0; r < 16; r++) begin
         for (int c = 0; c < 16; c++) begin
            d = rom_fn({3'(id), 4'(r), 4'(c)});
`ifdef BLIT_TRANSPARENT_EN
            if (d == 4'h0) continue;
`endif
            if (x + c < 640 && y + r < 480) begin
               exp_addr.push_back((y + r) * 640 + (x + c));
               exp_data.push_back(int'(d));
            end
         end
      end
   endtask

   function automatic int list_diffs();
      int b = 0;
      if (wr_addr.size() != exp_addr.size()) return 9999;
      for (int i = 0; i < wr_addr.size(); i++)
         if (wr_addr[i] != exp_addr[i] || wr_data[i] != exp_data[i]) b++;
      return b;
   endfunction

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic do_start(input int x, input int y, input int id);
      @(posedge CLK);
      #1;
      sprite_x  = 10'(x);
      sprite_y  = 10'(y);
      sprite_id = 3'(id);
      start     = 1'b1;
      st_cyc    = cyc;
      @(posedge CLK);
      #1;
      start = 1'b0;
   endtask

   task automatic test_reset();
      RESET_N = 1'b0; start = 1'b0; vblank = 1'b0;
      sprite_x = '0; sprite_y = '0; sprite_id = '0;
      wait_cycles(3);
      n_cmp++; if (fb_we !== 1'b0) begin n_bad++; $display("FAIL reset_fb_we got %b want 0", fb_we); end
      n_cmp++; if (fb_addr !== 20'd0) begin n_bad++; $display("FAIL reset_fb_addr got %0d want 0", fb_addr); end
      n_cmp++; if (fb_data !== 4'd0) begin n_bad++; $display("FAIL reset_fb_data got %0d want 0", fb_data); end
      n_cmp++; if (rom_addr !== 11'd0) begin n_bad++; $display("FAIL reset_rom_addr got %0d want 0", rom_addr); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
      RESET_N = 1'b1;
      wait_cycles(2);
   endtask

   task automatic test_basic();
      int first, last, d;
      vblank = 1'b1;
      clear_log();
      build_exp(100, 50, 2);
      do_start(100, 50, 2);
      wait_cycles(300);
      first = (wr_addr.size() > 0) ? wr_addr[0] : -1;
      last  = (wr_addr.size() > 0) ? wr_addr[wr_addr.size()-1] : -1;
      d     = list_diffs();
      n_cmp++; if (wr_addr.size() != 256) begin n_bad++; $display("FAIL basic_count got %0d want 256", wr_addr.size()); end
      n_cmp++; if (first != 32100) begin n_bad++; $display("FAIL basic_first_addr got %0d want 32100", first); end
      n_cmp++; if (last != 41715) begin n_bad++; $display("FAIL basic_last_addr got %0d want 41715", last); end
      n_cmp++; if (d != 0) begin n_bad++; $display("FAIL basic_write_list got %0d diffs want 0", d); end
      n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL basic_done_count got %0d want 1", done_cnt); end
      if (wr_cyc.size() > 0) begin
         n_cmp++; if (wr_cyc[0] != st_cyc + 4) begin n_bad++; $display("FAIL basic_latency got %0d want %0d", wr_cyc[0], st_cyc + 4); end
         n_cmp++; if (done_cyc != wr_cyc[wr_cyc.size()-1] + 1) begin n_bad++; $display("FAIL basic_done_cycle got %0d want %0d", done_cyc, wr_cyc[wr_cyc.size()-1] + 1); end
      end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_after got %b want 0", busy); end
   endtask

   task automatic test_wait_vblank();
      int busy_low = 0;
      int vb_cyc, d;
      vblank = 1'b0;
      clear_log();
      build_exp(100, 50, 2);
      do_start(100, 50, 2);
      repeat (40) begin
         @(negedge CLK);
         if (busy !== 1'b1) busy_low++;
      end
      n_cmp++; if (busy_low != 0) begin n_bad++; $display("FAIL wait_busy_held got %0d low cycles want 0", busy_low); end
      n_cmp++; if (wr_addr.size() != 0) begin n_bad++; $display("FAIL wait_no_writes got %0d want 0", wr_addr.size()); end
      @(posedge CLK);
      #1;
      vblank = 1'b1;
      vb_cyc = cyc;
      wait_cycles(300);
      d = list_diffs();
      n_cmp++; if (wr_addr.size() != 256) begin n_bad++; $display("FAIL wait_count got %0d want 256", wr_addr.size()); end
      n_cmp++; if (d != 0) begin n_bad++; $display("FAIL wait_write_list got %0d diffs want 0", d); end
      n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL wait_done_count got %0d want 1", done_cnt); end
      if (wr_cyc.size() > 0) begin
         n_cmp++; if (wr_cyc[0] != vb_cyc + 3) begin n_bad++; $display("FAIL wait_first_cycle got %0d want %0d", wr_cyc[0], vb_cyc + 3); end
      end
   endtask

   task automatic test_clip();
      int oob = 0;
      int d;
      vblank = 1'b1;
      clear_log();
      build_exp(630, 470, 1);
      do_start(630, 470, 1);
      wait_cycles(300);
      d = list_diffs();
      foreach (wr_addr[i])
         if ((wr_addr[i] % 640) < 630 || (wr_addr[i] / 640) < 470 || (wr_addr[i] / 640) >= 480) oob++;
      n_cmp++; if (wr_addr.size() != 100) begin n_bad++; $display("FAIL clip_count got %0d want 100", wr_addr.size()); end
      n_cmp++; if (d != 0) begin n_bad++; $display("FAIL clip_write_list got %0d diffs want 0", d); end
      n_cmp++; if (oob != 0) begin n_bad++; $display("FAIL clip_out_of_window got %0d want 0", oob); end
      n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL clip_done_count got %0d want 1", done_cnt); end
   endtask

   task automatic test_transparent();
      int want, d;
`ifdef BLIT_TRANSPARENT_EN
      want = 16;
`else
      want = 256;
`endif
      rom_mode = 1;
      vblank = 1'b1;
      clear_log();
      build_exp(0, 0, 3);
      do_start(0, 0, 3);
      wait_cycles(300);
      d = list_diffs();
      n_cmp++; if (wr_addr.size() != want) begin n_bad++; $display("FAIL transp_count got %0d want %0d", wr_addr.size(), want); end
      n_cmp++; if (d != 0) begin n_bad++; $display("FAIL transp_write_list got %0d diffs want 0", d); end
      rom_mode = 0;
   endtask

   task automatic test_reset_mid();
      int d;
      vblank = 1'b1;
      clear_log();
      do_start(200, 100, 4);
      while (cyc < st_cyc + 102) begin
         @(posedge CLK);
         #1;
      end
      RESET_N = 1'b0;
      @(posedge CLK);
      #1;
      RESET_N = 1'b1;
      n_cmp++; if (fb_we !== 1'b0) begin n_bad++; $display("FAIL abort_fb_we got %b want 0", fb_we); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b want 0", busy); end
      wait_cycles(300);
      n_cmp++; if (wr_addr.size() != 99) begin n_bad++; $display("FAIL abort_write_count got %0d want 99", wr_addr.size()); end
      n_cmp++; if (done_cnt != 0) begin n_bad++; $display("FAIL abort_no_done got %0d want 0", done_cnt); end
      clear_log();
      build_exp(200, 100, 4);
      do_start(200, 100, 4);
      wait_cycles(300);
      d = list_diffs();
      n_cmp++; if (d != 0) begin n_bad++; $display("FAIL abort_restart_list got %0d diffs want 0", d); end
      n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL abort_restart_done got %0d want 1", done_cnt); end
   endtask

   task automatic test_back_to_back();
      int d;
      vblank = 1'b1;
      clear_log();
      build_exp(10, 20, 5);
      do_start(10, 20, 5);
      wait_cycles(50);
      sprite_x = 10'd0;
      sprite_y = 10'd0;
      sprite_id = 3'd1;
      start = 1'b1;
      wait_cycles(1);
      start = 1'b0;
      wait_cycles(300);
      d = list_diffs();
      n_cmp++; if (wr_addr.size() != 256) begin n_bad++; $display("FAIL ignore_count got %0d want 256", wr_addr.size()); end
      n_cmp++; if (d != 0) begin n_bad++; $display("FAIL ignore_write_list got %0d diffs want 0", d); end
      n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL ignore_done_count got %0d want 1", done_cnt); end
      clear_log();
      wait_cycles(30);
      n_cmp++; if (wr_addr.size() != 0) begin n_bad++; $display("FAIL ignore_no_second_blit got %0d want 0", wr_addr.size()); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ignore_idle_busy got %b want 0", busy); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wait_vblank();
      test_clip();
      test_transparent();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
